// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions one raw mechanical pushbutton/switch pin in the CLK_IN domain.
// The pin is synchronised through two flops, normalised so that 1 means
// "pressed", and then qualified by a four-state FSM that only accepts a new
// level after STABLE_CYCLES consecutive identical samples. Accepted edges
// produce one-cycle press/release strobes and advance a wrapping press counter.
//
// Parameters
//   STABLE_CYCLES : identical synchronised samples needed to accept a level
//   CNT_WIDTH     : width of the stability counter (2**CNT_WIDTH > STABLE_CYCLES)
//   ACTIVE_LOW    : 1 = pin reads 0 when pressed, 0 = pin reads 1 when pressed
//   PRESS_WIDTH   : width of the press counter
//
// Ports
//   CLK_IN        : system clock, rising edge
//   RST_IN        : asynchronous reset, active-high
//   BTN_IN        : raw asynchronous button pin
//   PRESSED       : debounced level, 1 = pressed
//   PRESS_PULSE   : one-cycle strobe on an accepted press
//   RELEASE_PULSE : one-cycle strobe on an accepted release
//   PRESS_COUNT   : accepted presses, wraps modulo 2**PRESS_WIDTH
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int STABLE_CYCLES = 120000,
  parameter int CNT_WIDTH     = 17,
  parameter int ACTIVE_LOW    = 1,
  parameter int PRESS_WIDTH   = 8
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic                   BTN_IN,
  output logic                   PRESSED,
  output logic                   PRESS_PULSE,
  output logic                   RELEASE_PULSE,
  output logic [PRESS_WIDTH-1:0] PRESS_COUNT
);

  // Pin value seen when the button is not pressed; the synchroniser resets
  // to this so that reset release never looks like a press.
  localparam logic                 REL_LVL  = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_RELEASED = 2'd0,
    WAIT_PRESS    = 2'd1,
    IDLE_PRESSED  = 2'd2,
    WAIT_RELEASE  = 2'd3
  } state_t;

  logic                   sync_p0;
  logic                   sync_p1;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   ppulse_q, ppulse_d;
  logic                   rpulse_q, rpulse_d;
  logic [PRESS_WIDTH-1:0] count_q, count_d;

  // ---- stage p0/p1: two-flop synchroniser on the raw pin ----
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sync_p0 <= REL_LVL;
      sync_p1 <= REL_LVL;
    end else begin
      sync_p0 <= BTN_IN;
      sync_p1 <= sync_p0;
    end
  end

  // Polarity normalisation: s = 1 means pressed regardless of wiring.
  assign s = sync_p1 ^ REL_LVL;

  // ---- FSM + registered outputs ----
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q   <= IDLE_RELEASED;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      ppulse_q  <= 1'b0;
      rpulse_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      ppulse_q  <= ppulse_d;
      rpulse_q  <= rpulse_d;
      count_q   <= count_d;
    end
  end

  // The first differing sample already counts as 1, so the level is accepted
  // on the sample that finds the counter at STABLE_CYCLES-1; the counter is
  // therefore bounded and never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    ppulse_d  = 1'b0;
    rpulse_d  = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE_RELEASED: begin
        pressed_d = 1'b0;
        cnt_d     = '0;
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_PRESS: begin
        if (!s) begin
          state_d = IDLE_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_PRESSED;
          cnt_d     = '0;
          pressed_d = 1'b1;
          ppulse_d  = 1'b1;
          count_d   = count_q + PRESS_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_PRESSED: begin
        pressed_d = 1'b1;
        cnt_d     = '0;
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end

      WAIT_RELEASE: begin
        if (s) begin
          state_d = IDLE_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_RELEASED;
          cnt_d     = '0;
          pressed_d = 1'b0;
          rpulse_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = IDLE_RELEASED;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = ppulse_q;
  assign RELEASE_PULSE = rpulse_q;
  assign PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with STABLE_CYCLES=8, CNT_WIDTH=4,
// ACTIVE_LOW=1 and PRESS_WIDTH=2 (so the press counter wraps after 4 presses).
// A pin change driven just after edge k-1 is sampled at edge k and must show
// on PRESSED after edge k+9.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int PW = 2;

  logic          CLK_IN = 1'b0;
  logic          RST_IN;
  logic          BTN_IN;
  logic          PRESSED;
  logic          PRESS_PULSE;
  logic          RELEASE_PULSE;
  logic [PW-1:0] PRESS_COUNT;

  int n_chk   = 0;
  int n_bad   = 0;
  int exp_cnt = 0;

  button_debouncer #(
    .STABLE_CYCLES (N),
    .CNT_WIDTH     (CW),
    .ACTIVE_LOW    (1),
    .PRESS_WIDTH   (PW)
  ) dut (
    .CLK_IN        (CLK_IN),
    .RST_IN        (RST_IN),
    .BTN_IN        (BTN_IN),
    .PRESSED       (PRESSED),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .PRESS_COUNT   (PRESS_COUNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  // Checks every cycle for n cycles. ev_at = step index (1-based) at which an
  // accepted press (is_press=1) or release (is_press=0) is expected; 0 = none.
  task automatic watch(input int n, input int ev_at, input bit is_press, input bit lvl_before);
    bit exp_p;
    for (int i = 1; i <= n; i++) begin
      step();
      if (i == ev_at && is_press) exp_cnt = (exp_cnt + 1) % 4;
      exp_p = (ev_at != 0 && i >= ev_at) ? is_press : lvl_before;
      chk($sformatf("pressed@%0d", i), 32'(PRESSED), 32'(exp_p));
      chk($sformatf("ppulse@%0d", i), 32'(PRESS_PULSE), 32'((i == ev_at) && is_press));
      chk($sformatf("rpulse@%0d", i), 32'(RELEASE_PULSE), 32'((i == ev_at) && !is_press));
      chk($sformatf("count@%0d", i), 32'(PRESS_COUNT), 32'(exp_cnt));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pressed"}, 32'(PRESSED), 32'd0);
    chk({tag, "_ppulse"}, 32'(PRESS_PULSE), 32'd0);
    chk({tag, "_rpulse"}, 32'(RELEASE_PULSE), 32'd0);
    chk({tag, "_count"}, 32'(PRESS_COUNT), 32'd0);
  endtask

  initial begin
    RST_IN = 1'b1;
    BTN_IN = 1'b1;
    #2;
    chk_zero("por");
    step();
    step();
    RST_IN = 1'b0;
    exp_cnt = 0;

    // Idle after reset with the pin released
    watch(20, 0, 1'b0, 1'b0);

    // Clean press then clean release
    BTN_IN = 1'b0;
    watch(12, 10, 1'b1, 1'b0);
    BTN_IN = 1'b1;
    watch(12, 10, 1'b0, 1'b1);

    // Press again, then assert reset between edges with the pin low
    BTN_IN = 1'b0;
    watch(12, 10, 1'b1, 1'b0);
    chk("pre_rst_pressed", 32'(PRESSED), 32'd1);
    #3;
    RST_IN = 1'b1;
    #1;
    chk_zero("async_rst");
    exp_cnt = 0;
    BTN_IN = 1'b1;
    step();
    step();
    RST_IN = 1'b0;
    watch(100, 0, 1'b0, 1'b0);

    // Bounce: low phases of 3, 5, 7 cycles separated by short highs
    BTN_IN = 1'b0; watch(3, 0, 1'b0, 1'b0);
    BTN_IN = 1'b1; watch(2, 0, 1'b0, 1'b0);
    BTN_IN = 1'b0; watch(5, 0, 1'b0, 1'b0);
    BTN_IN = 1'b1; watch(2, 0, 1'b0, 1'b0);
    BTN_IN = 1'b0; watch(7, 0, 1'b0, 1'b0);
    BTN_IN = 1'b1; watch(2, 0, 1'b0, 1'b0);
    BTN_IN = 1'b0; watch(12, 10, 1'b1, 1'b0);
    BTN_IN = 1'b1; watch(12, 10, 1'b0, 1'b1);

    // Glitch: a 7-cycle low is rejected, then a clean press has full latency
    BTN_IN = 1'b0; watch(7, 0, 1'b0, 1'b0);
    BTN_IN = 1'b1; watch(20, 0, 1'b0, 1'b0);
    BTN_IN = 1'b0; watch(12, 10, 1'b1, 1'b0);
    // Release bounce: a 7-cycle high while pressed is rejected
    BTN_IN = 1'b1; watch(7, 0, 1'b0, 1'b1);
    BTN_IN = 1'b0; watch(20, 0, 1'b0, 1'b1);
    BTN_IN = 1'b1; watch(12, 10, 1'b0, 1'b1);

    // Reset while in WAIT_PRESS with the counter at 5
    BTN_IN = 1'b0;
    watch(7, 0, 1'b0, 1'b0);
    #2;
    RST_IN = 1'b1;
    #1;
    chk_zero("mid_rst");
    exp_cnt = 0;
    step();
    step();
    RST_IN = 1'b0;
    watch(12, 10, 1'b1, 1'b0);
    BTN_IN = 1'b1;
    watch(12, 10, 1'b0, 1'b1);

    // Wrap: five presses from reset give 1,2,3,0,1
    RST_IN = 1'b1;
    step();
    RST_IN = 1'b0;
    exp_cnt = 0;
    for (int p = 1; p <= 5; p++) begin
      BTN_IN = 1'b0;
      watch(12, 10, 1'b1, 1'b0);
      chk($sformatf("wrap%0d", p), 32'(PRESS_COUNT), 32'(p % 4));
      BTN_IN = 1'b1;
      watch(12, 10, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
